piso_serializer: RTL

- Parallel-in/serial-out stage that feeds the team's free-running N-bit right-shift register via its serial input.
- Accepts an N-bit word through a valid/ready handshake and emits it LSB-first, one bit per clock. An optional even-parity bit follows the word.
- After N valid bits, a same-width downstream right-shift register holds the word exactly, bit-aligned.

---
 rtl/piso_serializer_pkg.sv | 18 +
 rtl/piso_serializer_if.sv | 38 +++
 rtl/piso_serializer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the parallel-in/serial-out stage and its downstream shift register.
package piso_serializer_pkg;

    // Default word width, shared with the downstream right-shift register.
    localparam int unsigned DefaultWidth = 8;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StShift  = 2'd1,
        StParity = 2'd2
    } state_e;

    // Bit counter width: holds N-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Word handshake in, serial stream out.
interface piso_serializer_if
    import piso_serializer_pkg::*;
#(
    parameter int unsigned N = DefaultWidth
) ();

    logic [N-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic         serial_out;
    logic         serial_valid;
    logic         frame_start;
    logic         frame_done;

    // Serializer side.
    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output serial_out,
        output serial_valid,
        output frame_start,
        output frame_done
    );

    // Word source / stream consumer side.
    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  serial_out,
        input  serial_valid,
        input  frame_start,
        input  frame_done
    );

endinterface

// File: rtl/piso_serializer.sv
// Serializes an N-bit word LSB-first, one bit per clock, with optional trailing even parity.
// Frames run back-to-back without a gap when the next word is offered on the final bit.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int unsigned N          = DefaultWidth,
    parameter bit          PARITY_EN  = 1'b0,
    parameter bit          IDLE_LEVEL = 1'b0
) (
    input logic             clk,
    input logic             reset,
    piso_serializer_if.slave bus
);

    localparam int unsigned     CntW    = cnt_width(N);
    localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

    state_e          state_q, state_d;
    logic [N-1:0]    shift_q, shift_d;
    logic [CntW-1:0] count_q, count_d;
    logic            parity_q, parity_d;
    logic            serial_out_q, serial_out_d;
    logic            serial_valid_q, serial_valid_d;
    logic            frame_start_q, frame_start_d;
    logic            frame_done_q, frame_done_d;

    logic in_ready;
    logic accept;
    logic load;
    logic go_idle;

    // Ready in idle, in parity, or on the last data bit when no parity bit follows.
    always_comb begin
        in_ready = 1'b0;
        unique case (state_q)
            StIdle:   in_ready = 1'b1;
            StShift:  in_ready = (count_q == '0) && !PARITY_EN;
            StParity: in_ready = 1'b1;
            default:  in_ready = 1'b0;
        endcase
    end

    assign accept = bus.in_valid & in_ready;

    // Next-state and datapath decode.
    always_comb begin
        state_d        = state_q;
        shift_d        = shift_q;
        count_d        = count_q;
        parity_d       = parity_q;
        serial_out_d   = serial_out_q;
        serial_valid_d = serial_valid_q;
        frame_start_d  = 1'b0;
        frame_done_d   = 1'b0;
        load           = 1'b0;
        go_idle        = 1'b0;

        unique case (state_q)
            StIdle: begin
                load = accept;
            end
            StShift: begin
                if (count_q != '0) begin
                    serial_out_d = shift_q[0];
                    shift_d      = shift_q >> 1;
                    count_d      = count_q - CntW'(1);
                    // Next bit is the last data bit; it ends the frame only without parity.
                    frame_done_d = (count_q == CntW'(1)) && !PARITY_EN;
                end else if (PARITY_EN) begin
                    serial_out_d = parity_q;
                    frame_done_d = 1'b1;
                    state_d      = StParity;
                end else if (accept) begin
                    load = 1'b1;
                end else begin
                    go_idle = 1'b1;
                end
            end
            StParity: begin
                if (accept) begin
                    load = 1'b1;
                end else begin
                    go_idle = 1'b1;
                end
            end
            default: begin
                go_idle = 1'b1;
            end
        endcase

        if (load) begin
            serial_out_d   = bus.in_data[0];
            shift_d        = bus.in_data >> 1;
            count_d        = LastCnt;
            parity_d       = ^bus.in_data;
            serial_valid_d = 1'b1;
            frame_start_d  = 1'b1;
            state_d        = StShift;
        end

        if (go_idle) begin
            serial_out_d   = IDLE_LEVEL;
            serial_valid_d = 1'b0;
            count_d        = '0;
            parity_d       = 1'b0;
            state_d        = StIdle;
        end
    end

    // State and registered outputs; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= StIdle;
            shift_q        <= '0;
            count_q        <= '0;
            parity_q       <= 1'b0;
            serial_out_q   <= IDLE_LEVEL;
            serial_valid_q <= 1'b0;
            frame_start_q  <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            shift_q        <= shift_d;
            count_q        <= count_d;
            parity_q       <= parity_d;
            serial_out_q   <= serial_out_d;
            serial_valid_q <= serial_valid_d;
            frame_start_q  <= frame_start_d;
            frame_done_q   <= frame_done_d;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.serial_out   = serial_out_q;
    assign bus.serial_valid = serial_valid_q;
    assign bus.frame_start  = frame_start_q;
    assign bus.frame_done   = frame_done_q;

endmodule
